// File: rtl/cp0_regfile_pkg.sv
// ============================================================================
// Module : cp0_regfile_pkg
// Brief  : CP0 register numbers, exception codes, field indices and write masks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cp0_regfile_pkg;

  localparam logic [4:0] c_reg_badvaddr = 5'd8;
  localparam logic [4:0] c_reg_count    = 5'd9;
  localparam logic [4:0] c_reg_compare  = 5'd11;
  localparam logic [4:0] c_reg_status   = 5'd12;
  localparam logic [4:0] c_reg_cause    = 5'd13;
  localparam logic [4:0] c_reg_epc      = 5'd14;
  localparam logic [4:0] c_reg_prid     = 5'd15;

  localparam logic [31:0] c_exc_none = 32'h00;
  localparam logic [31:0] c_exc_int  = 32'h01;
  localparam logic [31:0] c_exc_adel = 32'h04;
  localparam logic [31:0] c_exc_ades = 32'h05;
  localparam logic [31:0] c_exc_sys  = 32'h08;
  localparam logic [31:0] c_exc_bp   = 32'h09;
  localparam logic [31:0] c_exc_ri   = 32'h0a;
  localparam logic [31:0] c_exc_ov   = 32'h0c;
  localparam logic [31:0] c_exc_trap = 32'h0d;
  localparam logic [31:0] c_exc_eret = 32'h0e;

  localparam logic [4:0] c_exccode_int = 5'h00;

  localparam int c_status_bev = 22;
  localparam int c_status_exl = 1;
  localparam int c_status_ie  = 0;
  localparam int c_cause_bd   = 31;
  localparam int c_cause_ti   = 30;

  localparam logic [31:0] c_status_reset = 32'h0040_0000;
  localparam logic [31:0] c_status_wmask = 32'h0000_ff03;
  localparam logic [31:0] c_cause_wmask  = 32'h0000_0300;

  typedef enum logic [1:0] {
    EXC_KIND_NONE    = 2'd0,
    EXC_KIND_TAKEN   = 2'd1,
    EXC_KIND_ERET    = 2'd2,
    EXC_KIND_UNKNOWN = 2'd3
  } exc_kind_e;

  function automatic exc_kind_e classify(input logic [31:0] exc_type);
    case (exc_type)
      c_exc_none: classify = EXC_KIND_NONE;
      c_exc_eret: classify = EXC_KIND_ERET;
      c_exc_int, c_exc_adel, c_exc_ades, c_exc_sys, c_exc_bp,
      c_exc_ri, c_exc_ov, c_exc_trap: classify = EXC_KIND_TAKEN;
      default:    classify = EXC_KIND_UNKNOWN;
    endcase
  endfunction

  // Interrupts report ExcCode 0; every other taken code maps straight through.
  function automatic logic [4:0] exc_code(input logic [31:0] exc_type);
    exc_code = (exc_type == c_exc_int) ? c_exccode_int : exc_type[4:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_regfile_if.sv
// ============================================================================
// Module : cp0_regfile_if
// Brief  : Pipeline-to-CP0 bundle: MTC0/MFC0, exception commit, status feedback.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cp0_regfile_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  hw_int_i;
  logic [31:0] exception_type_i;
  logic [31:0] pc_i;
  logic        in_delay_slot_i;
  logic [31:0] bad_vaddr_i;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int_o;
  logic        flush_o;
  logic [31:0] redirect_pc_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, hw_int_i, exception_type_i,
           pc_i, in_delay_slot_i, bad_vaddr_i,
    input  rdata_o, status_o, cause_o, epc_o, timer_int_o, flush_o, redirect_pc_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, hw_int_i, exception_type_i,
           pc_i, in_delay_slot_i, bad_vaddr_i,
    output rdata_o, status_o, cause_o, epc_o, timer_int_o, flush_o, redirect_pc_o
  );
endinterface

`default_nettype wire

// File: rtl/cp0_regfile_timer.sv
// ============================================================================
// Module : cp0_regfile_timer
// Brief  : Count/Compare pair with tick divider; TI only when CP0_TIMER_INT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_regfile_timer #(
  parameter int CNT_DIV_LOG2 = 1
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  input  wire logic        count_we_i,
  input  wire logic        compare_we_i,
  input  wire logic [31:0] wdata_i,
  output logic [31:0]      count_o,
  output logic [31:0]      compare_o,
  output logic             ti_o
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        w_inc;

  generate
    if (CNT_DIV_LOG2 > 0) begin : g_div
      logic [CNT_DIV_LOG2-1:0] r_tick;

      // A Count write restarts the divider so the next increment is a full period away.
      always_ff @(posedge clk_i) begin
        if (rst_i || count_we_i) r_tick <= '0;
        else                     r_tick <= r_tick + 1'b1;
      end

      assign w_inc = &r_tick;
    end else begin : g_nodiv
      assign w_inc = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i)           r_count <= '0;
    else if (count_we_i) r_count <= wdata_i;
    else if (w_inc)      r_count <= r_count + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)             r_compare <= '0;
    else if (compare_we_i) r_compare <= wdata_i;
  end

`ifdef CP0_TIMER_INT_EN
  logic r_ti;

  always_ff @(posedge clk_i) begin
    if (rst_i || compare_we_i) r_ti <= 1'b0;
    else if (!count_we_i && w_inc && ((r_count + 32'd1) == r_compare)) r_ti <= 1'b1;
  end

  assign ti_o = r_ti;
`else
  assign ti_o = 1'b0;
`endif

  assign count_o   = r_count;
  assign compare_o = r_compare;

endmodule

`default_nettype wire

// File: rtl/cp0_regfile.sv
// ============================================================================
// Module : cp0_regfile
// Brief  : CP0 register file and exception commit point (timer IRQ: CP0_TIMER_INT_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] PRID         = 32'h0000_4220,
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc0_0380,
  parameter int          CNT_DIV_LOG2 = 1
) (
  input wire logic     clk_i,
  input wire logic     rst_i,
  cp0_regfile_if.slave bus
);

  logic [7:0]  r_status_im;
  logic        r_status_exl;
  logic        r_status_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip_hw;
  logic [1:0]  r_cause_ip_sw;
  logic [4:0]  r_cause_exccode;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  exc_kind_e   w_kind;
  logic        w_flush;
  logic        w_mtc0;
  logic        w_ti;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_cur;
  logic [31:0] w_rdata;

  assign w_kind  = classify(bus.exception_type_i);
  assign w_flush = (bus.exception_type_i != c_exc_none);
  // Any flushing instruction squashes a same-cycle MTC0.
  assign w_mtc0  = bus.we_i && !w_flush;

  cp0_regfile_timer #(
    .CNT_DIV_LOG2 (CNT_DIV_LOG2)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .count_we_i   (w_mtc0 && (bus.waddr_i == c_reg_count)),
    .compare_we_i (w_mtc0 && (bus.waddr_i == c_reg_compare)),
    .wdata_i      (bus.wdata_i),
    .count_o      (w_count),
    .compare_o    (w_compare),
    .ti_o         (w_ti)
  );

  always_comb begin
    w_status                = c_status_reset;
    w_status[15:8]          = r_status_im;
    w_status[c_status_exl]  = r_status_exl;
    w_status[c_status_ie]   = r_status_ie;
  end

  always_comb begin
    w_cause              = '0;
    w_cause[c_cause_bd]  = r_cause_bd;
    w_cause[c_cause_ti]  = w_ti;
    w_cause[15:10]       = {r_cause_ip_hw[5] | w_ti, r_cause_ip_hw[4:0]};
    w_cause[9:8]         = r_cause_ip_sw;
    w_cause[6:2]         = r_cause_exccode;
  end

  always_comb begin
    case (bus.raddr_i)
      c_reg_badvaddr: w_cur = r_badvaddr;
      c_reg_count:    w_cur = w_count;
      c_reg_compare:  w_cur = w_compare;
      c_reg_status:   w_cur = w_status;
      c_reg_cause:    w_cur = w_cause;
      c_reg_epc:      w_cur = r_epc;
      c_reg_prid:     w_cur = PRID;
      default:        w_cur = '0;
    endcase
  end

  // MFC0 directly behind an MTC0 to the same register sees the value about to land.
  always_comb begin
    w_rdata = w_cur;
    if (bus.we_i && (bus.waddr_i == bus.raddr_i)) begin
      case (bus.raddr_i)
        c_reg_status: w_rdata = (w_cur & ~c_status_wmask) | (bus.wdata_i & c_status_wmask);
        c_reg_cause:  w_rdata = (w_cur & ~c_cause_wmask)  | (bus.wdata_i & c_cause_wmask);
        c_reg_count, c_reg_compare, c_reg_epc: w_rdata = bus.wdata_i;
        default:      w_rdata = w_cur;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_status_im     <= '0;
      r_status_exl    <= 1'b0;
      r_status_ie     <= 1'b0;
      r_cause_bd      <= 1'b0;
      r_cause_ip_hw   <= '0;
      r_cause_ip_sw   <= '0;
      r_cause_exccode <= '0;
      r_epc           <= '0;
      r_badvaddr      <= '0;
    end else begin
      r_cause_ip_hw <= bus.hw_int_i;
      if (w_kind == EXC_KIND_ERET) begin
        r_status_exl <= 1'b0;
      end else if (w_kind == EXC_KIND_TAKEN) begin
        // Nested exceptions keep the original return point.
        if (!r_status_exl) begin
          r_epc      <= bus.in_delay_slot_i ? (bus.pc_i - 32'd4) : bus.pc_i;
          r_cause_bd <= bus.in_delay_slot_i;
        end
        r_status_exl    <= 1'b1;
        r_cause_exccode <= exc_code(bus.exception_type_i);
        if ((bus.exception_type_i == c_exc_adel) || (bus.exception_type_i == c_exc_ades))
          r_badvaddr <= bus.bad_vaddr_i;
      end else if (w_mtc0) begin
        case (bus.waddr_i)
          c_reg_status: begin
            r_status_im  <= bus.wdata_i[15:8];
            r_status_exl <= bus.wdata_i[c_status_exl];
            r_status_ie  <= bus.wdata_i[c_status_ie];
          end
          c_reg_cause: r_cause_ip_sw <= bus.wdata_i[9:8];
          c_reg_epc:   r_epc         <= bus.wdata_i;
          default: ;
        endcase
      end
    end
  end

  assign bus.rdata_o       = w_rdata;
  assign bus.status_o      = w_status;
  assign bus.cause_o       = w_cause;
  assign bus.epc_o         = r_epc;
  assign bus.timer_int_o   = w_ti;
  assign bus.flush_o       = w_flush;
  assign bus.redirect_pc_o = (bus.exception_type_i == c_exc_eret) ? r_epc : EXC_VECTOR;

endmodule

`default_nettype wire

// File: tb/tb_cp0_regfile.sv
// ============================================================================
// Module : tb_cp0_regfile
// Brief  : Scoreboard bench for cp0_regfile with a field-level behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cp0_regfile;

  localparam logic [31:0] c_prid   = 32'h0000_4220;
  localparam logic [31:0] c_vector = 32'hbfc0_0380;
  localparam int          c_div    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cp0_regfile_if bus();

  cp0_regfile dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] redirect;
    logic        flush;
    logic        ti;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  // Reference state, held as architectural fields.
  logic [7:0]  m_im = '0;
  logic        m_exl = 1'b0, m_ie = 1'b0, m_bd = 1'b0, m_ti = 1'b0;
  logic [1:0]  m_ipsw = '0;
  logic [5:0]  m_hw = '0;
  logic [4:0]  m_exc = '0;
  logic [31:0] m_epc = '0, m_bad = '0, m_count = '0, m_compare = '0;
  int          m_age = 0;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0040_0000;
    s[15:8] = m_im;
    s[1] = m_exl;
    s[0] = m_ie;
    return s;
  endfunction

  function automatic logic [31:0] m_cause();
    logic [31:0] c;
    c = '0;
    c[31] = m_bd;
    c[30] = m_ti;
    c[15:10] = m_hw;
    c[15] = m_hw[5] | m_ti;
    c[9:8] = m_ipsw;
    c[6:2] = m_exc;
    return c;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_bad;
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status();
      5'd13: return m_cause();
      5'd14: return m_epc;
      5'd15: return c_prid;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: outputs are combinational and valid every cycle once stimulus is applied.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("rdata[%0d]", e.raddr), bus.rdata_o, e.rdata);
        chk("status", bus.status_o, e.status);
        chk("cause", bus.cause_o, e.cause);
        chk("epc", bus.epc_o, e.epc);
        chk("flush", {31'b0, bus.flush_o}, {31'b0, e.flush});
        chk("redirect", bus.redirect_pc_o, e.redirect);
        chk("timer_int", {31'b0, bus.timer_int_o}, {31'b0, e.ti});
      end
    end
  end

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [5:0] hw, input logic [31:0] ty,
                       input logic [31:0] pc, input logic ds, input logic [31:0] bad);
    exp_t e;
    logic [31:0] cur;
    logic taken;
    bus.we_i = we; bus.waddr_i = wa; bus.wdata_i = wd; bus.raddr_i = ra;
    bus.hw_int_i = hw; bus.exception_type_i = ty; bus.pc_i = pc;
    bus.in_delay_slot_i = ds; bus.bad_vaddr_i = bad;

    cur = m_read(ra);
    e.raddr = ra;
    e.rdata = cur;
    if (we && wa == ra) begin
      if (ra == 5'd12)      e.rdata = 32'h0040_0000 | (wd & 32'h0000_ff03);
      else if (ra == 5'd13) e.rdata = (cur & ~32'h300) | (wd & 32'h300);
      else if (ra == 5'd9 || ra == 5'd11 || ra == 5'd14) e.rdata = wd;
    end
    e.status   = m_status();
    e.cause    = m_cause();
    e.epc      = m_epc;
    e.flush    = (ty != 0);
    e.redirect = (ty == 32'h0e) ? m_epc : c_vector;
    e.ti       = m_ti;
    q.push_back(e);

    // Advance the model across the coming clock edge.
    taken = (ty == 1 || ty == 4 || ty == 5 || ty == 8 || ty == 9 ||
             ty == 32'h0a || ty == 32'h0c || ty == 32'h0d);
    m_hw = hw;
    if (ty == 32'h0e) m_exl = 1'b0;
    else if (taken) begin
      if (!m_exl) begin
        m_epc = ds ? pc - 4 : pc;
        m_bd  = ds;
      end
      m_exl = 1'b1;
      m_exc = (ty == 1) ? 5'd0 : ty[4:0];
      if (ty == 4 || ty == 5) m_bad = bad;
    end
    if (ty == 0 && we && wa == 5'd9) begin
      m_count = wd;
      m_age = 0;
    end else begin
      m_age++;
      if (m_age % c_div == 0) begin
        m_count = m_count + 1;
`ifdef CP0_TIMER_INT_EN
        if (m_count == m_compare && !(ty == 0 && we && wa == 5'd11)) m_ti = 1'b1;
`endif
      end
    end
    if (ty == 0 && we) begin
      case (wa)
        5'd11: begin m_compare = wd; m_ti = 1'b0; end
        5'd12: begin m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0]; end
        5'd13: m_ipsw = wd[9:8];
        5'd14: m_epc = wd;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] ra);
    drive(1'b0, 5'd0, 32'h0, ra, 6'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic exc(input logic [31:0] ty, input logic [31:0] pc, input logic ds,
                     input logic [31:0] bad, input logic [4:0] ra);
    drive(1'b0, 5'd0, 32'h0, ra, 6'h0, ty, pc, ds, bad);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra);
    drive(1'b1, wa, wd, ra, 6'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  logic [4:0]  addr_tbl [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
  logic [31:0] type_tbl [12] = '{32'h01, 32'h04, 32'h05, 32'h08, 32'h09, 32'h0a,
                                 32'h0c, 32'h0d, 32'h0e, 32'h0e, 32'h03, 32'h1f};

  initial begin
    logic [4:0]  wa, ra;
    logic [31:0] wd, ty;
    bus.we_i = 1'b0; bus.waddr_i = '0; bus.wdata_i = '0; bus.raddr_i = '0;
    bus.hw_int_i = '0; bus.exception_type_i = '0; bus.pc_i = '0;
    bus.in_delay_slot_i = 1'b0; bus.bad_vaddr_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    rd(5'd12); rd(5'd15); rd(5'd13); rd(5'd14); rd(5'd9);

    exc(32'h08, 32'hbfc0_0104, 1'b1, 32'h0, 5'd14);
    rd(5'd14); rd(5'd13);
    exc(32'h0c, 32'h8000_0010, 1'b0, 32'h0, 5'd14);
    rd(5'd13);
    exc(32'h0e, 32'h0, 1'b0, 32'h0, 5'd12);
    rd(5'd12);
    exc(32'h04, 32'h8000_0000, 1'b0, 32'h8000_0003, 5'd8);
    rd(5'd8); rd(5'd13);
    exc(32'h0e, 32'h0, 1'b0, 32'h0, 5'd12);
    drive(1'b1, 5'd12, 32'h0000_ff01, 5'd12, 6'h0, 32'h0a, 32'h8000_0020, 1'b0, 32'h0);
    rd(5'd12);
    exc(32'h0e, 32'h0, 1'b0, 32'h0, 5'd12);
    wr(5'd12, 32'hffff_a501, 5'd12);
    wr(5'd13, 32'hffff_ffff, 5'd13);

    wr(5'd11, 32'd5, 5'd11);
    wr(5'd9, 32'd0, 5'd9);
    repeat (12) rd(5'd13);
    wr(5'd11, 32'd100, 5'd13);
    rd(5'd13);
    wr(5'd9, 32'hffff_fffe, 5'd9);
    repeat (5) rd(5'd9);

    for (int i = 0; i < 600; i++) begin
      wa = addr_tbl[$urandom_range(0, 7)];
      ra = ($urandom_range(0, 3) == 0) ? wa : addr_tbl[$urandom_range(0, 7)];
      wd = $urandom;
      if (wa == 5'd11 && $urandom_range(0, 1) == 1) wd = m_count + $urandom_range(0, 6);
      ty = ($urandom_range(0, 5) == 0) ? type_tbl[$urandom_range(0, 11)] : 32'h0;
      drive($urandom_range(0, 2) == 0, wa, wd, ra, 6'($urandom), ty,
            {$urandom} & 32'hffff_fffc, 1'($urandom), $urandom);
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
